// File: rtl/gcd_controller_if.sv
// Handshake and datapath-control bundle between the GCD controller and the
// host/datapath side. The controller sits on the slave modport.
interface gcd_controller_if #(
  parameter int ITER_W = 8
);
  logic              start;
  logic              x_gt_y;
  logic              x_eq_y;
  logic              x_ls_y;
  logic              x_sel;
  logic              y_sel;
  logic              x_en;
  logic              y_en;
  logic [1:0]        x_op;
  logic [1:0]        y_op;
  logic              done_en;
  logic              busy;
  logic              done;
  logic              error;
  logic [ITER_W-1:0] iter_count;

  modport master (
    output start, x_gt_y, x_eq_y, x_ls_y,
    input  x_sel, y_sel, x_en, y_en, x_op, y_op,
    input  done_en, busy, done, error, iter_count
  );

  modport slave (
    input  start, x_gt_y, x_eq_y, x_ls_y,
    output x_sel, y_sel, x_en, y_en, x_op, y_op,
    output done_en, busy, done, error, iter_count
  );
endinterface

// File: rtl/gcd_controller.sv
// Control FSM for the 8-bit subtract-and-compare GCD datapath.
//
// state   | meaning
// IDLE    | waiting for start; iter_count holds last run's value
// LOAD    | load X/Y registers from the external operands
// COMPARE | inspect datapath flags, pick next step
// SUB_X   | X <= X - Y, count one step
// SUB_Y   | Y <= Y - X, count one step
// FINISH  | load result register
// DONE    | completion pulse
// ABORT   | completion + error pulse, result register untouched
module gcd_controller #(
  parameter int MAX_ITER = 255,
  parameter int ITER_W   = 8
) (
  input  logic            clk,
  input  logic            rst,
  gcd_controller_if.slave bus
);

  localparam logic [ITER_W-1:0] ITER_MAX = ITER_W'(MAX_ITER);

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    COMPARE = 3'd2,
    SUB_X   = 3'd3,
    SUB_Y   = 3'd4,
    FINISH  = 3'd5,
    DONE    = 3'd6,
    ABORT   = 3'd7
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ITER_W-1:0] iter_count;
  logic              iter_clr;
  logic              iter_inc;

  // State register, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Iteration counter: cleared on accepted start, saturates at ITER_MAX
  always_ff @(posedge clk) begin
    if (!rst) begin
      iter_count <= '0;
    end else if (iter_clr) begin
      iter_count <= '0;
    end else if (iter_inc && (iter_count != ITER_MAX)) begin
      iter_count <= iter_count + 1'b1;
    end
  end

  // Next-state decode; flag priority is eq > gt > lt
  always_comb begin
    state_next = IDLE;
    iter_clr   = 1'b0;
    iter_inc   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = LOAD;
          iter_clr   = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      LOAD:    state_next = COMPARE;
      COMPARE: begin
        if (bus.x_eq_y)                       state_next = FINISH;
        else if (!bus.x_gt_y && !bus.x_ls_y)  state_next = ABORT;
        else if (iter_count == ITER_MAX)      state_next = ABORT;
        else if (bus.x_gt_y)                  state_next = SUB_X;
        else                                  state_next = SUB_Y;
      end
      SUB_X: begin
        state_next = COMPARE;
        iter_inc   = 1'b1;
      end
      SUB_Y: begin
        state_next = COMPARE;
        iter_inc   = 1'b1;
      end
      FINISH:  state_next = DONE;
      DONE:    state_next = IDLE;
      ABORT:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Moore output decode from the state register
  always_comb begin
    bus.x_sel   = 1'b0;
    bus.y_sel   = 1'b0;
    bus.x_en    = 1'b0;
    bus.y_en    = 1'b0;
    bus.x_op    = OP_HOLD;
    bus.y_op    = OP_HOLD;
    bus.done_en = 1'b0;
    bus.busy    = (state != IDLE);
    bus.done    = 1'b0;
    bus.error   = 1'b0;
    case (state)
      LOAD: begin
        bus.x_en = 1'b1;
        bus.y_en = 1'b1;
      end
      SUB_X: begin
        bus.x_sel = 1'b1;
        bus.x_op  = OP_SUB;
        bus.x_en  = 1'b1;
      end
      SUB_Y: begin
        bus.y_sel = 1'b1;
        bus.y_op  = OP_SUB;
        bus.y_en  = 1'b1;
      end
      FINISH:  bus.done_en = 1'b1;
      DONE:    bus.done    = 1'b1;
      ABORT: begin
        bus.done  = 1'b1;
        bus.error = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.iter_count = iter_count;

endmodule

// File: tb/tb_gcd_controller.sv
// Directed bench for gcd_controller with a small behavioural GCD datapath.
module tb_gcd_controller;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  gcd_controller_if #(.ITER_W(8)) bus ();

  gcd_controller #(.MAX_ITER(255), .ITER_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural datapath
  logic [7:0] ext_x  = 8'd0;
  logic [7:0] ext_y  = 8'd0;
  logic [7:0] x_reg  = 8'd0;
  logic [7:0] y_reg  = 8'd0;
  logic [7:0] result = 8'd0;

  function automatic logic [7:0] alu(input logic [1:0] op, input logic [7:0] own,
                                     input logic [7:0] other, input logic [7:0] ext);
    case (op)
      2'b01:   return own - other;
      2'b10:   return ext;
      default: return own;
    endcase
  endfunction

  // Datapath register updates driven by controller outputs
  always @(posedge clk) begin
    if (bus.x_en) x_reg <= bus.x_sel ? alu(bus.x_op, x_reg, y_reg, ext_x) : ext_x;
    if (bus.y_en) y_reg <= bus.y_sel ? alu(bus.y_op, y_reg, x_reg, ext_y) : ext_y;
    if (bus.done_en) result <= x_reg;
  end

  assign bus.x_gt_y = (x_reg > y_reg);
  assign bus.x_eq_y = (x_reg == y_reg);
  assign bus.x_ls_y = (x_reg < y_reg);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] ctrl_vec();
    return {bus.x_sel, bus.y_sel, bus.x_en, bus.y_en, bus.x_op, bus.y_op,
            bus.done_en, bus.busy, bus.done, bus.error};
  endfunction

  // Drive operands and assert start at a negedge; the following posedge samples it
  task automatic launch(input logic [7:0] a, input logic [7:0] b, input bit hold);
    @(negedge clk);
    ext_x     = a;
    ext_y     = b;
    bus.start = 1'b1;
    @(negedge clk);
    if (!hold) bus.start = 1'b0;
  endtask

  // Wait (bounded) for done, then check latency, error, result, iter_count, done_en timing.
  // poke >= 0 re-pulses start for one cycle at that cycle offset while busy.
  task automatic check_run(input string tag, input int init_lat, input int exp_lat,
                           input logic exp_err, input logic [7:0] exp_res,
                           input logic [7:0] exp_iter, input int poke);
    int   lat;
    int   den_cnt;
    logic den_prev;
    bit   seen;
    lat      = init_lat;
    den_cnt  = 0;
    den_prev = bus.done_en;
    seen     = 1'b0;
    while (lat < 2000) begin
      if (bus.done_en) den_cnt++;
      den_prev = bus.done_en;
      @(negedge clk);
      lat++;
      if (poke >= 0 && lat == poke)     bus.start = 1'b1;
      if (poke >= 0 && lat == poke + 1) bus.start = 1'b0;
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_error"}, 32'(bus.error), 32'(exp_err));
      chk({tag, "_result"}, 32'(result), 32'(exp_res));
      chk({tag, "_iter"}, 32'(bus.iter_count), 32'(exp_iter));
      chk({tag, "_done_en_cnt"}, 32'(den_cnt), exp_err ? 32'd0 : 32'd1);
      chk({tag, "_done_en_prev"}, 32'(den_prev), exp_err ? 32'd0 : 32'd1);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    rst       = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_ctrl", 32'(ctrl_vec()), 32'd0);
    chk("reset_iter", 32'(bus.iter_count), 32'd0);
    rst = 1'b1;

    // 12,8: SUB_X then SUB_Y, gcd 4
    launch(8'd12, 8'd8, 1'b0);
    chk("r12_8_load_en", 32'({bus.x_en, bus.y_en, bus.x_sel, bus.y_sel}), 32'b1100);
    check_run("r12_8", 1, 8, 1'b0, 8'd4, 8'd2, -1);
    @(negedge clk);
    chk("r12_8_idle_busy", 32'(bus.busy), 32'd0);
    chk("r12_8_idle_iter_hold", 32'(bus.iter_count), 32'd2);

    // 9,9: no subtracts
    launch(8'd9, 8'd9, 1'b0);
    check_run("r9_9", 1, 4, 1'b0, 8'd9, 8'd0, -1);

    // 5,0: runaway, abort after 255 steps, result keeps 9
    launch(8'd5, 8'd0, 1'b0);
    check_run("r5_0", 1, 4 + 2*255 - 1, 1'b1, 8'd9, 8'd255, -1);
    @(negedge clk);
    chk("r5_0_after_iter", 32'(bus.iter_count), 32'd255);

    // 255,1: 254 steps, no abort
    launch(8'd255, 8'd1, 1'b0);
    check_run("r255_1", 1, 4 + 2*254, 1'b0, 8'd1, 8'd254, -1);

    // Mid-run reset during SUB_Y
    launch(8'd12, 8'd8, 1'b0);
    begin
      int n;
      n = 0;
      while (!(bus.y_en && bus.y_sel) && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("mrst_reached_sub_y", 32'(bus.y_en && bus.y_sel), 32'd1);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_ctrl", 32'(ctrl_vec()), 32'd0);
    chk("mrst_iter", 32'(bus.iter_count), 32'd0);
    rst = 1'b1;
    launch(8'd12, 8'd8, 1'b0);
    check_run("mrst_fresh", 1, 8, 1'b0, 8'd4, 8'd2, -1);

    // start re-pulsed while busy (during COMPARE) is ignored
    launch(8'd9, 8'd9, 1'b0);
    check_run("poke", 1, 4, 1'b0, 8'd9, 8'd0, 2);
    @(negedge clk);
    chk("poke_idle", 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk("poke_no_queue", 32'(bus.busy), 32'd0);

    // start held through DONE: IDLE for one cycle, then LOAD
    launch(8'd20, 8'd15, 1'b1);
    check_run("hold", 1, 10, 1'b0, 8'd5, 8'd3, -1);
    @(negedge clk);
    chk("hold_idle", 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk("hold_load", 32'({bus.busy, bus.x_en, bus.y_en}), 32'b111);
    bus.start = 1'b0;
    check_run("hold2", 1, 10, 1'b0, 8'd5, 8'd3, -1);

    // 0,0: finishes with result 0
    launch(8'd0, 8'd0, 1'b0);
    check_run("r0_0", 1, 4, 1'b0, 8'd0, 8'd0, -1);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
